// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the Ethernet transmit path: framer state encoding,
// line constants, CRC-32 constants and the FCS byte-ordering helper.
// ---------------------------------------------------------------------------
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_DROP
    } eth_state_t;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [7:0]  ETH_PAD         = 8'h00;

    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] ETH_CRC_POLY    = 32'h04C1_1DB7;
    // Register value a receiver sees after running data+FCS through crc_n.
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704_DD7B;

    // FCS byte k on the line: bit i = ~crc[31-8k-i].
    function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] k);
        logic [7:0] raw;
        case (k)
            2'd0:    raw = crc[31:24];
            2'd1:    raw = crc[23:16];
            2'd2:    raw = crc[15:8];
            default: raw = crc[7:0];
        endcase
        return ~{raw[0], raw[1], raw[2], raw[3], raw[4], raw[5], raw[6], raw[7]};
    endfunction

endpackage

// File: rtl/crc_n.sv
// ---------------------------------------------------------------------------
// crc_n
// Byte-wide Ethernet CRC-32 generator. The register is kept in MSB-first
// form while each data byte is absorbed LSB first (line bit order).
// Ports:
//   clk      in   clock
//   rst      in   synchronous, active-high: register <= 0xFFFFFFFF
//   crc_en   in   absorb data_in this cycle
//   data_in  in   8-bit data byte
//   crc_out  out  current CRC register
// ---------------------------------------------------------------------------
module crc_n
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        crc_en,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] crc_q;
    logic [31:0] crc_next;
    logic [7:0]  d;

    always_comb begin
        crc_next = crc_q;
        d        = data_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (crc_next[31] ^ d[0]) begin
                crc_next = {crc_next[30:0], 1'b0} ^ ETH_CRC_POLY;
            end else begin
                crc_next = {crc_next[30:0], 1'b0};
            end
            d = {1'b0, d[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= ETH_CRC_INIT;
        end else if (crc_en) begin
            crc_q <= crc_next;
        end
    end

    assign crc_out = crc_q;

endmodule

// File: rtl/eth_tx_framer.sv
// ---------------------------------------------------------------------------
// eth_tx_framer
// Wraps a valid/ready/last byte stream into a full Ethernet frame on a
// GMII-style line: preamble, SFD, data, zero pad to MIN_FRAME, FCS, IFG.
// A missing byte mid-frame aborts with a tx_er marker and the rest of the
// frame is drained silently.
// Ports:
//   clk       in   byte clock
//   rst_n     in   synchronous, active-low reset
//   s_data    in   frame byte (destination MAC first)
//   s_valid   in   s_data valid
//   s_last    in   final byte of frame
//   s_ready   out  byte accepted this cycle (DATA / DROP only)
//   tx_data   out  line byte (registered)
//   tx_en     out  line byte valid (registered)
//   tx_er     out  abort marker (registered)
//   busy      out  state is not IDLE
//   underrun  out  one-cycle pulse on a mid-frame abort
// ---------------------------------------------------------------------------
module eth_tx_framer
    import eth_pkg::*;
#(
    parameter int unsigned MIN_FRAME      = 60,
    parameter int unsigned IFG_BYTES      = 12,
    parameter int unsigned PREAMBLE_BYTES = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       busy,
    output logic       underrun
);

    localparam logic [11:0] MIN_W    = 12'(MIN_FRAME);
    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_BYTES - 1);
    // The IDLE cycle that precedes PRE is itself one idle byte-time, so the
    // IFG state only covers the remaining IFG_BYTES-1.
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 2);
    localparam eth_state_t  AFTER_TX = (IFG_BYTES > 1) ? ST_IFG : ST_IDLE;

    eth_state_t  state, state_next;
    logic [10:0] cnt, cnt_d, cnt_sat;
    logic [11:0] cnt_inc;
    logic [7:0]  tcnt, tcnt_d;
    logic [7:0]  tx_data_d;
    logic        tx_en_d, tx_er_d, underrun_d;
    logic        ready_c;
    logic        crc_en;
    logic        crc_rst_q;
    logic [31:0] crc_out;

    assign cnt_inc = {1'b0, cnt} + 12'd1;
    assign cnt_sat = (cnt == '1) ? cnt : cnt_inc[10:0];

    always_comb begin
        state_next = state;
        cnt_d      = cnt;
        tcnt_d     = tcnt;
        tx_data_d  = '0;
        tx_en_d    = 1'b0;
        tx_er_d    = 1'b0;
        underrun_d = 1'b0;
        crc_en     = 1'b0;
        ready_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_valid) begin
                    state_next = ST_PRE;
                    tcnt_d     = '0;
                end
            end
            ST_PRE: begin
                tx_data_d = ETH_PREAMBLE;
                tx_en_d   = 1'b1;
                if (tcnt == PRE_LAST) begin
                    state_next = ST_SFD;
                end else begin
                    tcnt_d = tcnt + 8'd1;
                end
            end
            ST_SFD: begin
                tx_data_d  = ETH_SFD;
                tx_en_d    = 1'b1;
                cnt_d      = '0;
                tcnt_d     = '0;
                state_next = ST_DATA;
            end
            ST_DATA: begin
                ready_c = 1'b1;
                tx_en_d = 1'b1;
                if (s_valid) begin
                    tx_data_d = s_data;
                    crc_en    = 1'b1;
                    cnt_d     = cnt_sat;
                    if (s_last) begin
                        state_next = (cnt_inc < MIN_W) ? ST_PAD : ST_FCS;
                    end
                end else begin
                    tx_er_d    = 1'b1;
                    underrun_d = 1'b1;
                    state_next = ST_DROP;
                end
            end
            ST_PAD: begin
                tx_data_d = ETH_PAD;
                tx_en_d   = 1'b1;
                crc_en    = 1'b1;
                cnt_d     = cnt_sat;
                if (cnt_inc >= MIN_W) begin
                    state_next = ST_FCS;
                end
            end
            ST_FCS: begin
                tx_data_d = fcs_byte(crc_out, tcnt[1:0]);
                tx_en_d   = 1'b1;
                if (tcnt == 8'd3) begin
                    tcnt_d     = '0;
                    state_next = AFTER_TX;
                end else begin
                    tcnt_d = tcnt + 8'd1;
                end
            end
            ST_IFG: begin
                if (tcnt == IFG_LAST) begin
                    state_next = ST_IDLE;
                end else begin
                    tcnt_d = tcnt + 8'd1;
                end
            end
            ST_DROP: begin
                ready_c = 1'b1;
                if (s_valid && s_last) begin
                    tcnt_d     = '0;
                    state_next = AFTER_TX;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            tcnt      <= '0;
            tx_data   <= '0;
            tx_en     <= 1'b0;
            tx_er     <= 1'b0;
            underrun  <= 1'b0;
            crc_rst_q <= 1'b1;
        end else begin
            state     <= state_next;
            cnt       <= cnt_d;
            tcnt      <= tcnt_d;
            tx_data   <= tx_data_d;
            tx_en     <= tx_en_d;
            tx_er     <= tx_er_d;
            underrun  <= underrun_d;
            crc_rst_q <= (state == ST_IDLE);
        end
    end

    assign s_ready = ready_c & rst_n;
    assign busy    = (state != ST_IDLE);

    // rst_n is also applied directly so the CRC is forced on every reset edge,
    // not only from the second one onwards.
    crc_n u_crc (
        .clk     (clk),
        .rst     (crc_rst_q | ~rst_n),
        .crc_en  (crc_en),
        .data_in (tx_data_d),
        .crc_out (crc_out)
    );

endmodule

// File: tb/tb_eth_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_framer
// Two framer instances: u_dut (MIN_FRAME=60) carries the vector table and
// random frames; u_dut0 (MIN_FRAME=0) carries the "123456789" golden frame.
// Expected line bytes come from a reflected CRC-32 reference model.
// ---------------------------------------------------------------------------
module tb_eth_tx_framer;
    import eth_pkg::*;

    localparam int MINF = 60;
    localparam int IFG  = 12;
    localparam int PRE  = 7;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid, s_last, s_ready;
    logic [7:0] tx_data;
    logic       tx_en, tx_er, busy, underrun;

    logic [7:0] d0_s_data;
    logic       d0_s_valid, d0_s_last, d0_s_ready;
    logic [7:0] d0_tx_data;
    logic       d0_tx_en, d0_tx_er, d0_busy, d0_underrun;

    eth_tx_framer #(.MIN_FRAME(MINF), .IFG_BYTES(IFG), .PREAMBLE_BYTES(PRE)) u_dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .tx_data(tx_data), .tx_en(tx_en), .tx_er(tx_er),
        .busy(busy), .underrun(underrun)
    );

    eth_tx_framer #(.MIN_FRAME(0), .IFG_BYTES(IFG), .PREAMBLE_BYTES(PRE)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .s_data(d0_s_data), .s_valid(d0_s_valid), .s_last(d0_s_last),
        .s_ready(d0_s_ready), .tx_data(d0_tx_data), .tx_en(d0_tx_en), .tx_er(d0_tx_er),
        .busy(d0_busy), .underrun(d0_underrun)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [8:0]  mon_q[$];
    logic [8:0]  exp_q[$];
    logic [7:0]  mon0_q[$];
    logic [7:0]  pay[$];
    int          gap_q[$];
    int          rdy_cnt  = 0;
    int          urun_cnt = 0;
    int          gap_run  = 0;
    bit          seen_frame = 1'b0;
    logic        prev_en = 1'b0;
    logic [31:0] rev_residue;

    typedef struct {
        int len;
        int stall_at;
        int rst_at;
        int exp_txen;
        int exp_ready;
        int exp_urun;
    } vec_t;

    vec_t vt[11];

    always @(negedge clk) begin
        if (tx_en) mon_q.push_back({tx_er, tx_data});
        if (s_ready) rdy_cnt++;
        if (underrun) urun_cnt++;
        if (tx_en && !prev_en && seen_frame) gap_q.push_back(gap_run);
        if (tx_en) begin
            gap_run    = 0;
            seen_frame = 1'b1;
        end else begin
            gap_run++;
        end
        prev_en = tx_en;
        if (d0_tx_en) mon0_q.push_back(d0_tx_data);
    end

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Reflected (LSB-first) CRC-32 register after absorbing q, no final invert.
    function automatic logic [31:0] crc_raw(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (q[k]) begin
            c = c ^ {24'h0, q[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic gen_payload(input int len);
        pay.delete();
        for (int k = 0; k < len; k++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic build_exp(input int len, input int stall_at, input int rst_at);
        logic [7:0]  q[$];
        logic [31:0] c;
        for (int k = 0; k < PRE; k++) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5);
        if (rst_at >= 0) begin
            for (int k = 0; k < rst_at; k++) exp_q.push_back({1'b0, pay[k]});
        end else if (stall_at >= 0) begin
            for (int k = 0; k < stall_at; k++) exp_q.push_back({1'b0, pay[k]});
            exp_q.push_back(9'h100);
        end else begin
            for (int k = 0; k < len; k++) q.push_back(pay[k]);
            while (q.size() < MINF) q.push_back(8'h00);
            c = ~crc_raw(q);
            foreach (q[k]) exp_q.push_back({1'b0, q[k]});
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back({1'b0, c[7:0]});
                c = c >> 8;
            end
        end
    endtask

    task automatic send_frame(input int len, input int stall_at, input int rst_at);
        int i = 0;
        int guard = 0;
        bit stalled = 1'b0;
        bit hs;
        while (i < len && guard < 4000) begin
            guard++;
            if (i == rst_at) begin
                rst_n   = 1'b0;
                s_valid = 1'b0;
                s_last  = 1'b0;
                @(posedge clk); #1;
                check("midreset_outputs", int'({tx_data, tx_en, tx_er, s_ready, busy, underrun}), 0);
                rst_n = 1'b1;
                break;
            end
            if (i == stall_at && !stalled) begin
                s_valid = 1'b0;
                stalled = 1'b1;
                @(posedge clk); #1;
                continue;
            end
            s_valid = 1'b1;
            s_data  = pay[i];
            s_last  = (i == len - 1);
            @(negedge clk);
            hs = s_ready;
            @(posedge clk); #1;
            if (hs) i++;
        end
        check("send_timeout", int'(guard >= 4000), 0);
    endtask

    task automatic finish_frame(input string name, input int exp_txen, input int exp_ready,
                                input int exp_urun, input bit good);
        int guard = 0;
        int mism  = -1;
        logic [7:0]  rq[$];
        logic [31:0] res;
        s_valid = 1'b0;
        s_last  = 1'b0;
        do begin
            @(negedge clk);
            guard++;
        end while (busy && guard < 3000);
        check({name, "_timeout"}, int'(guard >= 3000), 0);
        check({name, "_txen"}, mon_q.size(), exp_txen);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k >= mon_q.size() || mon_q[k] !== exp_q[k]) begin
                mism = k;
                break;
            end
        end
        if (mism < 0 && mon_q.size() != exp_q.size()) mism = exp_q.size();
        n_vec++;
        if (mism >= 0) begin
            n_bad++;
            $display("FAIL %s_bytes: index %0d got {er,data}=0x%0h required 0x%0h", name, mism,
                     (mism < mon_q.size()) ? mon_q[mism] : 9'h1FF,
                     (mism < exp_q.size()) ? exp_q[mism] : 9'h1FF);
        end
        check({name, "_ready"}, rdy_cnt, exp_ready);
        check({name, "_underrun"}, urun_cnt, exp_urun);
        if (good) begin
            for (int k = PRE + 1; k < mon_q.size(); k++) rq.push_back(mon_q[k][7:0]);
            res = crc_raw(rq);
            check({name, "_residue"}, int'(res), int'(rev_residue));
        end
        mon_q.delete();
        exp_q.delete();
        rdy_cnt  = 0;
        urun_cnt = 0;
    endtask

    initial begin
        logic [31:0] rr;
        logic [7:0]  gold0[21];
        string       str;
        int          i, guard, len, la, lb;
        bit          hs;

        rr = ETH_CRC_RESIDUE;
        rev_residue = '0;
        for (int k = 0; k < 32; k++) begin
            rev_residue = {rev_residue[30:0], rr[0]};
            rr = rr >> 1;
        end

        rst_n      = 1'b0;
        s_valid    = 1'b1;
        s_data     = 8'hAA;
        s_last     = 1'b0;
        d0_s_valid = 1'b0;
        d0_s_data  = 8'h00;
        d0_s_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", int'({tx_data, tx_en, tx_er, s_ready, busy, underrun}), 0);
        rst_n   = 1'b1;
        s_valid = 1'b0;
        @(posedge clk); #1;

        // Golden frame without padding.
        str = "123456789";
        for (int k = 0; k < 7; k++) gold0[k] = 8'h55;
        gold0[7] = 8'hD5;
        for (int k = 0; k < 9; k++) gold0[8 + k] = 8'h31 + 8'(k);
        gold0[17] = 8'h26; gold0[18] = 8'h39; gold0[19] = 8'hF4; gold0[20] = 8'hCB;
        i = 0;
        guard = 0;
        d0_s_valid = 1'b1;
        while (i < 9 && guard < 500) begin
            guard++;
            d0_s_data = str[i];
            d0_s_last = (i == 8);
            @(negedge clk);
            hs = d0_s_ready;
            @(posedge clk); #1;
            if (hs) i++;
        end
        d0_s_valid = 1'b0;
        d0_s_last  = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (d0_busy && guard < 500);
        check("golden_timeout", int'(guard >= 500), 0);
        check("golden_txen", mon0_q.size(), 21);
        for (int k = 0; k < 21; k++) begin
            if (k < mon0_q.size()) check($sformatf("golden_byte%0d", k), int'(mon0_q[k]), int'(gold0[k]));
        end

        vt[0]  = '{14, -1, -1, 72, 14, 0};
        vt[1]  = '{60, -1, -1, 72, 60, 0};
        vt[2]  = '{1,  -1, -1, 72, 1,  0};
        vt[3]  = '{59, -1, -1, 72, 59, 0};
        vt[4]  = '{61, -1, -1, 73, 61, 0};
        vt[5]  = '{100,-1, -1, 112,100,0};
        vt[6]  = '{64, 20, -1, 29, 65, 1};
        vt[7]  = '{10, -1, -1, 72, 10, 0};
        vt[8]  = '{40, -1, 10, 18, 10, 0};
        vt[9]  = '{14, -1, -1, 72, 14, 0};
        vt[10] = '{64, 1,  -1, 10, 65, 1};

        for (int v = 0; v < 11; v++) begin
            gen_payload(vt[v].len);
            build_exp(vt[v].len, vt[v].stall_at, vt[v].rst_at);
            send_frame(vt[v].len, vt[v].stall_at, vt[v].rst_at);
            finish_frame($sformatf("vec%0d", v), vt[v].exp_txen, vt[v].exp_ready, vt[v].exp_urun,
                         (vt[v].stall_at < 0) && (vt[v].rst_at < 0));
        end

        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(1, 120);
            gen_payload(len);
            build_exp(len, -1, -1);
            send_frame(len, -1, -1);
            finish_frame($sformatf("rand%0d_len%0d", r, len), PRE + 1 + ((len > MINF) ? len : MINF) + 4,
                         len, 0, 1'b1);
        end

        // Back-to-back: s_valid stays high from the last byte of A into B.
        la = 30;
        lb = 70;
        gen_payload(la);
        build_exp(la, -1, -1);
        send_frame(la, -1, -1);
        gen_payload(lb);
        build_exp(lb, -1, -1);
        send_frame(lb, -1, -1);
        finish_frame("b2b", 72 + PRE + 1 + lb + 4, la + lb, 0, 1'b0);
        check("b2b_gap_seen", int'(gap_q.size() > 0), 1);
        if (gap_q.size() > 0) check("b2b_gap", gap_q[gap_q.size() - 1], IFG);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
